recfn_to_fn_iter: RTL and testbench
===================================

# recfn_to_fn_iter

Sequential converter from HardFloat recoded floating-point (recFN, `expWidth+1`-bit exponent) back to standard IEEE-754 interchange format (fN). It is the reverse of the fN-to-recFN input converter and sits at the output boundary of the float datapath, before results are stored or handed to non-float logic. Results are returned under a Calyx-style `go`/`done` handshake. Subnormal results are denormalized by an iterative one-bit-per-cycle right shifter, so the block needs no wide barrel shifter.

## Interface
Parameters:
- `expWidth`, default 8: IEEE exponent width (≥3).
- `sigWidth`, default 24: significand width including the hidden bit (≥3).
- `inputWidth`, default 33: recFN width; must equal `expWidth+sigWidth+1`.
- `outputWidth`, default 32: fN width; must equal `expWidth+sigWidth`.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `go`  in  1  start request; sampled only in IDLE.
- `in_`  in  `inputWidth`  recFN operand `{sign, exp[expWidth:0], fract[sigWidth-2:0]}`; sampled on the accepted `go` edge.
- `out`  out  `outputWidth`  fN result `{sign, expOut[expWidth-1:0], fractOut[sigWidth-2:0]}`; held until the next accepted `go`.
- `done`  out  1  one-cycle pulse when `out` is valid.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE with `go`=1: register the sign, the fraction and the classification of `in_`, then move on.
  - If the operand is subnormal, load the shift register with `{1'b1, fract}` and load the counter with `d`, then go to SHIFT.
  - Otherwise go directly to DONE.
- IDLE with `go`=0: stay in IDLE.
- Classification uses `exp[expWidth:expWidth-2]`:
  - 000: zero. Output is exp 0, fract 0.
  - 110: infinity. Output is exp all-ones, fract 0.
  - 111: NaN. Output is exp all-ones; fract is the payload (see Configuration).
- For other exponent values, with `minNormExp = 2^(expWidth-1)+2`:
  - `exp < minNormExp`: subnormal. Shift distance is `d = minNormExp - exp`, range 1..`sigWidth-1`. The counter is `clog2(sigWidth)` bits.
  - Otherwise normal. `expOut = (exp - (2^(expWidth-1)+1))[expWidth-1:0]` and `fractOut = fract`.
- SHIFT: each cycle, shift the register right by 1 with zero fill and decrement the counter. When the counter reaches 1 in this cycle, go to DONE.
  - The subnormal result is `expOut=0` and `fractOut` = low `sigWidth-1` bits of the register. Truncation is exact because the recFN source was exact.
- DONE: drive the final `out`, pulse `done`=1 for one cycle, and return to IDLE.
- The sign always passes through, including for zero, infinity and NaN.
- `go` while in SHIFT or DONE is ignored and not queued.
- `in_` may change freely after acceptance.
- Reset mid-operation aborts the conversion. The next cycle is IDLE with `out`=0 and `done`=0.

## Timing
- Reset values: state IDLE, `out`=0, `done`=0, counter 0, shift register 0.
- `go` accepted at edge t. The `done` pulse appears:
  - in cycle t+1 for normal, zero, infinity and NaN operands;
  - in cycle t+1+d for subnormal operands. The worst case is t+`sigWidth` (t+24 at the defaults).
- `out` updates on the same edge that raises `done`, then stays stable until that edge in the next conversion.
- Back-to-back: `go` may be asserted in the cycle after `done`. Minimum issue interval is 2 cycles.
- `go` held high continuously restarts a conversion every time IDLE is re-entered.

## Configuration
- `RECFN_TO_FN_CANON_NAN_EN`
  - Defined: every NaN output is the canonical quiet NaN: sign 0, exp all-ones, fract MSB 1, remaining fract bits 0.
  - Undefined: the NaN's sign and fraction pass through unchanged. Payloads from quiet recFN sources keep fract nonzero.

## Test plan
All scenarios use defaults 8/24; `go` is accepted at edge t.
- Normal: `in_`=33'h080000000 (1.0) -> `out`=32'h3F800000; `done` in cycle t+1. Also `in_`=33'h180000000 -> `out`=32'hBF800000.
- Zero and infinity:
  - 33'h000000000 -> 32'h00000000.
  - 33'h0C0000000 -> 32'h7F800000.
  - 33'h1C0000000 -> 32'hFF800000.
  - All with `done` at t+1.
- Subnormal extremes (SHIFT path):
  - 33'h040800000 -> 32'h00400000; `done` at t+2.
  - 33'h035800000 -> 32'h00000001; `done` at t+24.
- NaN: 33'h0E0000001 -> 32'h7F800001 without the macro, 32'h7FC00000 with `RECFN_TO_FN_CANON_NAN_EN`.
- Busy and reset:
  - Start 33'h035800000. Pulse `go` with 1.0 at t+5: it is ignored, and `out`=32'h00000001 at t+24.
  - Repeat the start, then assert `reset` at t+10: `out`=0, `done` never pulses, IDLE at t+11.
  - A new `go` at t+12 with 1.0 gives `out`=32'h3F800000 at t+13.

Source files
------------

// File: rtl/recfn_to_fn_iter_if.sv
// Handshake bundle for recfn_to_fn_iter: go/in_ request side, out/done result side.
// master = requester (drives go, in_), slave = converter.
interface recfn_to_fn_iter_if #(
  parameter int inputWidth  = 33,
  parameter int outputWidth = 32
);
  logic                   go;
  logic [inputWidth-1:0]  in_;
  logic [outputWidth-1:0] out;
  logic                   done;

  modport master (output go, in_, input out, done);
  modport slave  (input go, in_, output out, done);
endinterface

// File: rtl/recfn_to_fn_iter.sv
// recFN -> IEEE fN converter; subnormals are denormalised one bit per cycle.
// Optional macro RECFN_TO_FN_CANON_NAN_EN: emit the canonical quiet NaN for every NaN input.
module recfn_to_fn_iter #(
  parameter int expWidth    = 8,
  parameter int sigWidth    = 24,
  parameter int inputWidth  = 33,
  parameter int outputWidth = 32
) (
  input  logic clk,
  input  logic reset,
  recfn_to_fn_iter_if.slave io
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam int EW1   = expWidth + 1;
  localparam int FW    = sigWidth - 1;
  localparam int CNT_W = $clog2(sigWidth);

  localparam logic [EW1-1:0]      MIN_NORM_EXP = EW1'((1 << (expWidth - 1)) + 2);
  localparam logic [CNT_W-1:0]    MIN_NORM_LO  = CNT_W'((1 << (expWidth - 1)) + 2);
  localparam logic [expWidth-1:0] BIAS_ADJ     = expWidth'((1 << (expWidth - 1)) + 1);

  // Operand fields
  logic [inputWidth-1:0] in_w;
  logic                  in_sign;
  logic [EW1-1:0]        in_exp;
  logic [FW-1:0]         in_fract;
  logic [2:0]            in_cls;

  assign in_w     = io.in_;
  assign in_sign  = in_w[inputWidth-1];
  assign in_exp   = in_w[inputWidth-2:FW];
  assign in_fract = in_w[FW-1:0];
  assign in_cls   = in_exp[expWidth -: 3];

  state_t                 state_q, state_d;
  logic                   sign_q, sign_d;
  logic [expWidth-1:0]    exp_q, exp_d;
  logic [sigWidth-1:0]    sh_q, sh_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [outputWidth-1:0] out_q, out_d;
  logic                   done_q, done_d;

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (io.go) begin
          sign_d  = in_sign;
          state_d = DONE;
          unique case (in_cls)
            3'b000: begin
              exp_d = '0;
              sh_d  = '0;
            end
            3'b110: begin
              exp_d = '1;
              sh_d  = '0;
            end
            3'b111: begin
              exp_d = '1;
`ifdef RECFN_TO_FN_CANON_NAN_EN
              sign_d         = 1'b0;
              sh_d           = '0;
              sh_d[FW-1]     = 1'b1;
`else
              sh_d  = {1'b0, in_fract};
`endif
            end
            default: begin
              if (in_exp < MIN_NORM_EXP) begin
                // Hidden bit made explicit; distance fits the counter by construction.
                exp_d   = '0;
                sh_d    = {1'b1, in_fract};
                cnt_d   = MIN_NORM_LO - in_exp[CNT_W-1:0];
                state_d = SHIFT;
              end else begin
                exp_d = in_exp[expWidth-1:0] - BIAS_ADJ;
                sh_d  = {1'b0, in_fract};
              end
            end
          endcase
        end
      end
      SHIFT: begin
        sh_d  = sh_q >> 1;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = DONE;
      end
      DONE: begin
        out_d   = {sign_q, exp_q, sh_q[FW-1:0]};
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      sh_q    <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  assign io.out  = out_q;
  assign io.done = done_q;

endmodule

// File: tb/tb_recfn_to_fn_iter.sv
// Directed bench for recfn_to_fn_iter (8/24): arithmetic reference model checked
// every cycle, plus literal expectations for result values and latencies.
module tb_recfn_to_fn_iter;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  recfn_to_fn_iter_if #(.inputWidth(33), .outputWidth(32)) io ();

  recfn_to_fn_iter #(
    .expWidth(8), .sigWidth(24), .inputWidth(33), .outputWidth(32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .io    (io.slave)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: decode the recFN value and rebuild the IEEE word directly.
  function automatic logic [31:0] model_out(input logic [32:0] v, output int lat);
    logic s;
    int   e;
    int   f;
    s   = v[32];
    e   = int'(v[31:23]);
    f   = int'(v[22:0]);
    lat = 1;
    case (e / 64)
      0: return {s, 31'd0};
      6: return {s, 8'hFF, 23'd0};
      7: begin
`ifdef RECFN_TO_FN_CANON_NAN_EN
        return 32'h7FC00000;
`else
        return {s, 8'hFF, v[22:0]};
`endif
      end
      default: begin
        if (e < 130) begin
          lat = 1 + (130 - e);
          return {s, 8'd0, 23'((f + (1 << 23)) >> (130 - e))};
        end
        return {s, 8'(e - 129), v[22:0]};
      end
    endcase
  endfunction

  // Model timeline: tracks accepted requests and when each result must appear.
  int          edge_n = 0;
  int          m_done_cyc = -1;
  int          m_lat;
  bit          m_busy = 1'b0;
  bit          m_done_flag = 1'b0;
  logic [31:0] m_out = '0;
  logic [31:0] m_pend = '0;
  bit          chk_en = 1'b0;

  always @(posedge clk) begin
    edge_n++;
    m_done_flag = 1'b0;
    if (reset) begin
      m_busy = 1'b0;
      m_out  = '0;
    end else if (m_busy && edge_n == m_done_cyc) begin
      m_out       = m_pend;
      m_busy      = 1'b0;
      m_done_flag = 1'b1;
    end else if (!m_busy && io.go) begin
      m_pend     = model_out(io.in_, m_lat);
      m_done_cyc = edge_n + m_lat;
      m_busy     = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cycle_done", {31'd0, io.done}, {31'd0, m_done_flag});
      check("cycle_out", io.out, m_out);
    end
  end

  // Present v for one accept edge; returns at the negedge following that edge.
  task automatic start(input logic [32:0] v);
    @(negedge clk);
    io.in_ = v;
    io.go  = 1'b1;
    @(negedge clk);
    io.go  = 1'b0;
    io.in_ = '1;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!io.done && n < 40);
    check("done_timeout", {31'd0, io.done}, 32'd1);
  endtask

  task automatic convert(input string name, input logic [32:0] v,
                         input logic [31:0] exp_out, input int exp_lat);
    int n;
    start(v);
    wait_done(n);
    check({name, "_out"}, io.out, exp_out);
    check({name, "_lat"}, 32'(n), 32'(exp_lat));
  endtask

  typedef struct {
    string       name;
    logic [32:0] in_v;
    logic [31:0] out_v;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int n;
    int dcnt;

    #100000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int dcnt;

    reset  = 1'b1;
    io.go  = 1'b0;
    io.in_ = '0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("rst_out", io.out, 32'h0);
    check("rst_done", {31'd0, io.done}, 32'd0);
    reset = 1'b0;

    vecs.push_back('{"one",      33'h080000000, 32'h3F800000, 1});
    vecs.push_back('{"neg_one",  33'h180000000, 32'hBF800000, 1});
    vecs.push_back('{"two_5",    33'h080A00000, 32'h40200000, 1});
    vecs.push_back('{"zero",     33'h000000000, 32'h00000000, 1});
    vecs.push_back('{"pos_inf",  33'h0C0000000, 32'h7F800000, 1});
    vecs.push_back('{"neg_inf",  33'h1C0000000, 32'hFF800000, 1});
    vecs.push_back('{"sub_d1",   33'h040800000, 32'h00400000, 2});
    vecs.push_back('{"sub_d23",  33'h035800000, 32'h00000001, 24});
    vecs.push_back('{"sub_d5",   33'h03EFFFFE0, 32'h0007FFFF, 6});
    vecs.push_back('{"sub_neg",  33'h13EFFFFE0, 32'h8007FFFF, 6});
`ifdef RECFN_TO_FN_CANON_NAN_EN
    vecs.push_back('{"nan",      33'h0E0000001, 32'h7FC00000, 1});
    vecs.push_back('{"nan_neg",  33'h1E0400000, 32'h7FC00000, 1});
`else
    vecs.push_back('{"nan",      33'h0E0000001, 32'h7F800001, 1});
    vecs.push_back('{"nan_neg",  33'h1E0400000, 32'hFFC00000, 1});
`endif

    foreach (vecs[i]) convert(vecs[i].name, vecs[i].in_v, vecs[i].out_v, vecs[i].lat);

    // go during SHIFT is ignored: pulse at t+5, result still lands at t+24
    start(33'h035800000);
    repeat (4) @(negedge clk);
    io.in_ = 33'h080000000;
    io.go  = 1'b1;
    @(negedge clk);
    io.go  = 1'b0;
    wait_done(n);
    check("busy_out", io.out, 32'h00000001);
    check("busy_lat", 32'(n + 5), 32'd24);

    // Reset at t+10 aborts; a fresh go at t+12 completes at t+13
    start(33'h035800000);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_out", io.out, 32'h0);
    check("abort_done", {31'd0, io.done}, 32'd0);
    reset = 1'b0;
    convert("after_rst", 33'h080000000, 32'h3F800000, 1);

    // go held high: a new conversion every 2 cycles
    @(negedge clk);
    io.in_ = 33'h180000000;
    io.go  = 1'b1;
    dcnt   = 0;
    repeat (10) begin
      @(negedge clk);
      if (io.done) dcnt++;
    end
    io.go = 1'b0;
    check("held_go_dones", 32'(dcnt), 32'd5);
    check("held_go_out", io.out, 32'hBF800000);

    repeat (30) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
